// File: rtl/vdp_arb_pkg.sv
// rtl/vdp_arb_pkg.sv - shared constants and state encoding for the pixel-bus arbiter
package vdp_arb_pkg;
   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;
   localparam int CNT_W   = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GRANT = 2'b01,
      GAP   = 2'b10
   } arb_state_e;
endpackage

// File: rtl/decoder_1x4.sv
// rtl/decoder_1x4.sv - 2-to-4 one-hot decoder
module decoder_1x4 (
   input  logic [1:0] sel,
   output logic [3:0] y
);
   assign y = 4'b0001 << sel;
endmodule

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational round-robin pick over four requesters
module rr_pick4
   import vdp_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic [SEL_W-1:0]   idx,
   output logic               any
);
   // Scan from farthest to nearest so the candidate closest to ptr wins.
   always_comb begin
      idx = ptr;
      any = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[ptr + SEL_W'(k)]) begin
            idx = ptr + SEL_W'(k);
            any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/decoder_rr_arbiter.sv
// rtl/decoder_rr_arbiter.sv - round-robin pixel-bus arbiter with burst limit and turnaround gap
module decoder_rr_arbiter
   import vdp_arb_pkg::*;
#(
   parameter int MAX_BURST = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [SEL_W-1:0]   sel,
   output logic               gnt_vld,
   output logic [NUM_REQ-1:0] gnt,
   output logic               preempt
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   arb_state_e        state_q, state_d;
   logic [SEL_W-1:0]  ptr_q, ptr_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              preempt_q, preempt_d;
   logic [SEL_W-1:0]  pick_idx;
   logic              pick_any;
   logic [NUM_REQ-1:0] dec_y;

   rr_pick4 u_pick (
      .req (req),
      .ptr (ptr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

   decoder_1x4 u_dec (
      .sel (sel_q),
      .y   (dec_y)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         sel_q     <= '0;
         cnt_q     <= '0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         preempt_q <= preempt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      preempt_d = 1'b0;
      case (state_q)
         GRANT: begin
            // Release outranks the burst limit, so a coinciding drop never pulses preempt.
            if (!req[sel_q]) begin
               state_d = GAP;
               ptr_d   = sel_q + 2'd1;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = GAP;
               ptr_d     = sel_q + 2'd1;
               preempt_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            if (pick_any) begin
               state_d = GRANT;
               sel_d   = pick_idx;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_comb begin
      gnt_vld = (state_q == GRANT);
      gnt     = dec_y & {NUM_REQ{gnt_vld}};
      sel     = sel_q;
      preempt = preempt_q;
   end
endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// tb/tb_decoder_rr_arbiter.sv - self-checking bench for decoder_rr_arbiter
module tb_decoder_rr_arbiter;
   localparam int MB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [1:0] sel;
   logic       gnt_vld;
   logic [3:0] gnt;
   logic       preempt;

   int checks = 0;
   int errors = 0;

   bit m_busy  = 1'b0;
   bit m_pre   = 1'b0;
   int m_owner = 0;
   int m_len   = 0;
   int m_start = 0;

   decoder_rr_arbiter #(.MAX_BURST(MB)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .sel     (sel),
      .gnt_vld (gnt_vld),
      .gnt     (gnt),
      .preempt (preempt)
   );

   always #5 clk = ~clk;

   wire [7:0] act_vec = {sel, gnt_vld, gnt, preempt};

   function automatic int pick(logic [3:0] r, int start);
      for (int k = 0; k < 4; k++) begin
         if (r[(start + k) % 4]) return (start + k) % 4;
      end
      return -1;
   endfunction

   // Model: m_len counts grant cycles already served by the current owner.
   function automatic void model_update(logic [3:0] r, logic rs);
      int p;
      if (rs) begin
         m_busy = 0; m_pre = 0; m_owner = 0; m_len = 0; m_start = 0;
      end else if (m_busy) begin
         m_len = m_len + 1;
         m_pre = 0;
         if (!r[m_owner]) begin
            m_busy = 0; m_start = (m_owner + 1) % 4;
         end else if (m_len == MB) begin
            m_busy = 0; m_pre = 1; m_start = (m_owner + 1) % 4;
         end
      end else begin
         m_pre = 0;
         p = pick(r, m_start);
         if (p >= 0) begin
            m_busy = 1; m_owner = p; m_len = 0;
         end
      end
   endfunction

   function automatic logic [7:0] exp_vec();
      logic [3:0] g;
      g = m_busy ? (4'b0001 << m_owner) : 4'b0000;
      return {2'(m_owner), m_busy, g, m_pre};
   endfunction

   task automatic step();
      @(posedge clk);
      model_update(req, rst);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = 4'b0000;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 4'b1111;
      step();
      step();
      checks++;
      if (act_vec !== 8'h00) begin
         errors++; $display("FAIL reset: got %b expected %b", act_vec, 8'h00);
      end
      rst = 1'b0; req = 4'b0000;
   endtask

   task automatic test_idle();
      req = 4'b0000;
      for (int c = 0; c < 10; c++) begin
         step();
         checks++;
         if (act_vec !== 8'h00) begin
            errors++; $display("FAIL idle c%0d: got %b expected %b", c, act_vec, 8'h00);
         end
      end
   endtask

   task automatic test_single_release();
      req = 4'b0100;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (act_vec !== {2'd2, 1'b1, 4'b0100, 1'b0}) begin
            errors++; $display("FAIL single_grant c%0d: got %b expected %b", c, act_vec, {2'd2, 1'b1, 4'b0100, 1'b0});
         end
      end
      req = 4'b0000;
      for (int c = 0; c < 2; c++) begin
         step();
         checks++;
         if (act_vec !== {2'd2, 1'b0, 4'b0000, 1'b0}) begin
            errors++; $display("FAIL single_gap_idle c%0d: got %b expected %b", c, act_vec, {2'd2, 1'b0, 4'b0000, 1'b0});
         end
      end
   endtask

   task automatic test_all_preempt();
      logic [7:0] e;
      do_reset();
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         for (int c = 0; c < MB; c++) begin
            step();
            e = {2'(g % 4), 1'b1, 4'(1 << (g % 4)), 1'b0};
            checks++;
            if (act_vec !== e) begin
               errors++; $display("FAIL preempt_grant g%0d c%0d: got %b expected %b", g, c, act_vec, e);
            end
         end
         if (g < 4) begin
            step();
            e = {2'(g % 4), 1'b0, 4'b0000, 1'b1};
            checks++;
            if (act_vec !== e) begin
               errors++; $display("FAIL preempt_gap g%0d: got %b expected %b", g, act_vec, e);
            end
         end
      end
      req = 4'b0000;
      step();
      step();
   endtask

   task automatic test_ptr_rotation();
      logic [7:0] e;
      do_reset();
      req = 4'b0001;
      step();
      step();
      req = 4'b0010;
      step();
      e = {2'd0, 1'b0, 4'b0000, 1'b0};
      checks++;
      if (act_vec !== e) begin
         errors++; $display("FAIL rot_gap: got %b expected %b", act_vec, e);
      end
      req = 4'b0011;
      step();
      e = {2'd1, 1'b1, 4'b0010, 1'b0};
      checks++;
      if (act_vec !== e) begin
         errors++; $display("FAIL rot_next: got %b expected %b", act_vec, e);
      end
      req = 4'b0001;
      step();
      step();
      e = {2'd0, 1'b1, 4'b0001, 1'b0};
      checks++;
      if (act_vec !== e) begin
         errors++; $display("FAIL rot_served0: got %b expected %b", act_vec, e);
      end
      req = 4'b0000;
      step();
      step();
   endtask

   task automatic test_release_at_limit();
      logic [7:0] e;
      do_reset();
      req = 4'b1000;
      for (int c = 0; c < MB; c++) step();
      req = 4'b0000;
      step();
      e = {2'd3, 1'b0, 4'b0000, 1'b0};
      checks++;
      if (act_vec !== e) begin
         errors++; $display("FAIL release_at_limit: got %b expected %b", act_vec, e);
      end
      step();
   endtask

   task automatic test_reset_mid_grant();
      logic [7:0] e;
      do_reset();
      req = 4'b1000;
      step();
      step();
      rst = 1'b1;
      step();
      checks++;
      if (act_vec !== 8'h00) begin
         errors++; $display("FAIL rst_mid_grant: got %b expected %b", act_vec, 8'h00);
      end
      rst = 1'b0;
      step();
      e = {2'd3, 1'b1, 4'b1000, 1'b0};
      checks++;
      if (act_vec !== e) begin
         errors++; $display("FAIL rst_regrant: got %b expected %b", act_vec, e);
      end
      req = 4'b0000;
      step();
      step();
   endtask

   task automatic test_random();
      logic [7:0] e;
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom);
         rst = ($urandom_range(0, 63) == 0);
         step();
         e = exp_vec();
         checks++;
         if (act_vec !== e) begin
            errors++; $display("FAIL random c%0d: got %b expected %b", c, act_vec, e);
         end
      end
      rst = 1'b0; req = 4'b0000;
      step();
      step();
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single_release();
      test_all_preempt();
      test_ptr_rotation();
      test_release_at_limit();
      test_reset_mid_grant();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
